// File: rtl/timer_disp_scan_if.sv
// Bus between the timer value source and the display scanner.
//   min_sw      timer minutes (0..59 legal)
//   sec_sw      timer seconds (0..59 legal)
//   secc_sw     timer tenths of a second (0..9 legal)
//   digit_an    one-hot digit enable pads, bit4=M10 .. bit0=C
//   seg         segment pads {g,f,e,d,c,b,a}
//   dp          decimal point pad of the current digit
//   frame_start one-cycle pulse on the first cycle of every frame
// master: drives the timer values and observes the display.
// slave : the scanner itself.
interface timer_disp_scan_if;
  logic [5:0] min_sw;
  logic [5:0] sec_sw;
  logic [3:0] secc_sw;
  logic [4:0] digit_an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output min_sw, sec_sw, secc_sw,
    input  digit_an, seg, dp, frame_start
  );

  modport slave (
    input  min_sw, sec_sw, secc_sw,
    output digit_an, seg, dp, frame_start
  );
endinterface

// File: rtl/timer_disp_scan.sv
// Five-digit multiplexed 7-segment scanner showing the timer as MM.SS.C.
// A snapshot of the timer is taken on entry to the M10 slot so a frame never
// mixes two timer values. Outputs are registered and reflect the slot and
// snapshot being loaded at the same edge.
// Ports:
//   clk      system clock
//   reset_n  asynchronous reset, active low
//   bus      timer_disp_scan_if.slave (timer inputs, display pad outputs)
// Parameters:
//   SCAN_DIV clocks per digit slot (>=1)
//   LZ_BLANK 1: blank the minute-tens digit when it is zero
//   ACT_LOW  1: pad outputs active-low
module timer_disp_scan #(
  parameter int SCAN_DIV = 4,
  parameter int LZ_BLANK = 1,
  parameter int ACT_LOW  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  timer_disp_scan_if.slave bus
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic             POL      = (ACT_LOW != 0);
  localparam logic             LZ       = (LZ_BLANK != 0);
  localparam logic [6:0]       DASH     = 7'h40;

  typedef enum logic [2:0] {
    SLOT_M10 = 3'd0,
    SLOT_M1  = 3'd1,
    SLOT_S10 = 3'd2,
    SLOT_S1  = 3'd3,
    SLOT_C   = 3'd4
  } slot_t;

  slot_t            slot_q, slot_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             primed_q;
  logic             tick, enter;
  logic [5:0]       min_q, min_d, sec_q, sec_d;
  logic [3:0]       secc_q, secc_d;
  logic [7:0]       min_dec, sec_dec;
  logic             min_bad, sec_bad, secc_bad;
  logic [4:0]       an_p0, an_p1;
  logic [6:0]       seg_p0, seg_p1;
  logic             dp_p0, dp_p1, fs_p0, fs_p1;

  // Divide-free split of 0..63 into {tens, ones} by repeated subtraction.
  function automatic logic [7:0] dec_split(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = DASH;
    endcase
    return s;
  endfunction

  // Scan control: slot advance, and snapshot load on frame entry. The first
  // edge after reset behaves like a frame entry so the display starts at M10.
  always_comb begin
    tick   = primed_q && (div_q == DIV_LAST);
    enter  = !primed_q || (tick && (slot_q == SLOT_C));
    div_d  = (tick || !primed_q) ? '0 : div_q + DIV_W'(1);
    slot_d = slot_q;
    if (!primed_q) begin
      slot_d = SLOT_M10;
    end else if (tick) begin
      case (slot_q)
        SLOT_M10: slot_d = SLOT_M1;
        SLOT_M1:  slot_d = SLOT_S10;
        SLOT_S10: slot_d = SLOT_S1;
        SLOT_S1:  slot_d = SLOT_C;
        default:  slot_d = SLOT_M10;
      endcase
    end
    min_d  = enter ? bus.min_sw  : min_q;
    sec_d  = enter ? bus.sec_sw  : sec_q;
    secc_d = enter ? bus.secc_sw : secc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= SLOT_M10;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Stage p0: logical digit image from the slot and snapshot being loaded.
  always_comb begin
    min_dec  = dec_split(min_d);
    sec_dec  = dec_split(sec_d);
    min_bad  = (min_d > 6'd59);
    sec_bad  = (sec_d > 6'd59);
    secc_bad = (secc_d > 4'd9);
    an_p0    = 5'b00000;
    seg_p0   = 7'h00;
    dp_p0    = 1'b0;
    fs_p0    = enter;
    case (slot_d)
      SLOT_M10: begin
        an_p0 = 5'b10000;
        if (min_bad)
          seg_p0 = DASH;
        else if (LZ && (min_dec[7:4] == 4'd0))
          seg_p0 = 7'h00;
        else
          seg_p0 = seg_code(min_dec[7:4]);
      end
      SLOT_M1: begin
        an_p0  = 5'b01000;
        seg_p0 = min_bad ? DASH : seg_code(min_dec[3:0]);
        dp_p0  = 1'b1;
      end
      SLOT_S10: begin
        an_p0  = 5'b00100;
        seg_p0 = sec_bad ? DASH : seg_code(sec_dec[7:4]);
      end
      SLOT_S1: begin
        an_p0  = 5'b00010;
        seg_p0 = sec_bad ? DASH : seg_code(sec_dec[3:0]);
        dp_p0  = 1'b1;
      end
      default: begin
        an_p0  = 5'b00001;
        seg_p0 = secc_bad ? DASH : seg_code(secc_d);
      end
    endcase
  end

  // Stage p1: registered pads, polarity applied; reset leaves the display dark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      primed_q <= 1'b0;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      secc_q   <= 4'd0;
      an_p1    <= {5{POL}};
      seg_p1   <= {7{POL}};
      dp_p1    <= POL;
      fs_p1    <= 1'b0;
    end else begin
      div_q    <= div_d;
      primed_q <= 1'b1;
      min_q    <= min_d;
      sec_q    <= sec_d;
      secc_q   <= secc_d;
      an_p1    <= an_p0 ^ {5{POL}};
      seg_p1   <= seg_p0 ^ {7{POL}};
      dp_p1    <= dp_p0 ^ POL;
      fs_p1    <= fs_p0;
    end
  end

  assign bus.digit_an    = an_p1;
  assign bus.seg         = seg_p1;
  assign bus.dp          = dp_p1;
  assign bus.frame_start = fs_p1;

endmodule

// File: tb/tb_timer_disp_scan.sv
module tb_timer_disp_scan;

  logic       clk;
  logic       reset_n;
  logic [5:0] min_v, sec_v;
  logic [3:0] secc_v;

  timer_disp_scan_if ifa ();
  timer_disp_scan_if ifb ();

  assign ifa.min_sw  = min_v;
  assign ifa.sec_sw  = sec_v;
  assign ifa.secc_sw = secc_v;
  assign ifb.min_sw  = min_v;
  assign ifb.sec_sw  = sec_v;
  assign ifb.secc_sw = secc_v;

  timer_disp_scan #(.SCAN_DIV(4), .LZ_BLANK(1), .ACT_LOW(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
  );

  timer_disp_scan #(.SCAN_DIV(1), .LZ_BLANK(1), .ACT_LOW(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } pads_t;

  typedef struct packed {
    logic [5:0]      mn;
    logic [5:0]      sc;
    logic [3:0]      cc;
    logic [4:0][6:0] seg;   // seg[4] = M10 ... seg[0] = C
  } vec_t;

  // Reference model state: cycles since the first edge after reset (-1 in
  // reset) and the timer value latched at the start of the current frame.
  int ka = -1, kb = -1;
  int sa_m, sa_s, sa_c, sb_m, sb_s, sb_c;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic pads_t model_pads(input int k, input int mn, input int sc,
                                       input int cc, input int d, input bit act,
                                       input bit lz);
    pads_t p;
    int    slot;
    int    dig[5];
    bit    bad[5];
    p = '0;
    if (k >= 0) begin
      slot   = (k / d) % 5;
      p.fs   = ((k % (5 * d)) == 0);
      dig[0] = mn / 10; dig[1] = mn % 10;
      dig[2] = sc / 10; dig[3] = sc % 10;
      dig[4] = cc;
      bad[0] = (mn > 59); bad[1] = (mn > 59);
      bad[2] = (sc > 59); bad[3] = (sc > 59);
      bad[4] = (cc > 9);
      p.an   = 5'(32'd16 >> slot);
      p.seg  = bad[slot] ? 7'h40 : seg_of(dig[slot]);
      p.dp   = (slot == 1 || slot == 3);
      if (slot == 0 && lz && !bad[0] && dig[0] == 0) begin
        p.seg = 7'h00;
        p.dp  = 1'b0;
      end
    end
    if (act) begin
      p.an  = ~p.an;
      p.seg = ~p.seg;
      p.dp  = ~p.dp;
    end
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      ka = -1;
      kb = -1;
    end else begin
      ka++;
      kb++;
      if (ka % 20 == 0) begin sa_m = int'(min_v); sa_s = int'(sec_v); sa_c = int'(secc_v); end
      if (kb % 5 == 0)  begin sb_m = int'(min_v); sb_s = int'(sec_v); sb_c = int'(secc_v); end
    end
  endtask

  task automatic check_all(input string tag);
    pads_t ea, eb;
    ea = model_pads(ka, sa_m, sa_s, sa_c, 4, 1'b0, 1'b1);
    eb = model_pads(kb, sb_m, sb_s, sb_c, 1, 1'b1, 1'b1);
    chk({tag, ".a.an"},  ifa.digit_an,    ea.an);
    chk({tag, ".a.seg"}, ifa.seg,         ea.seg);
    chk({tag, ".a.dp"},  ifa.dp,          ea.dp);
    chk({tag, ".a.fs"},  ifa.frame_start, ea.fs);
    chk({tag, ".b.an"},  ifb.digit_an,    eb.an);
    chk({tag, ".b.seg"}, ifb.seg,         eb.seg);
    chk({tag, ".b.dp"},  ifb.dp,          eb.dp);
    chk({tag, ".b.fs"},  ifb.frame_start, eb.fs);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ifa.frame_start !== 1'b1 && n < 40);
    chk("wait_frame", ifa.frame_start, 1'b1);
  endtask

  // Check one whole frame of DUT A against a table entry; optionally change
  // the timer inputs after cycle chg_j of the frame.
  task automatic run_frame(input vec_t v, input int chg_j, input logic [5:0] nm,
                           input logic [5:0] ns, input logic [3:0] nc);
    wait_frame();
    for (int j = 0; j < 20; j++) begin
      int s;
      if (j > 0) tick();
      s = j / 4;
      chk("frm.an",  ifa.digit_an, 32'(5'b10000 >> s));
      chk("frm.seg", ifa.seg, v.seg[4-s]);
      chk("frm.dp",  ifa.dp, (s == 1 || s == 3) ? 32'd1 : 32'd0);
      chk("frm.fs",  ifa.frame_start, (j == 0) ? 32'd1 : 32'd0);
      if (j == chg_j) begin
        min_v = nm; sec_v = ns; secc_v = nc;
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{mn: 6'd12, sc: 6'd34, cc: 4'd5,  seg: {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D}};
    vecs[1] = '{mn: 6'd56, sc: 6'd7,  cc: 4'd8,  seg: {7'h6D, 7'h7D, 7'h3F, 7'h07, 7'h7F}};
    vecs[2] = '{mn: 6'd62, sc: 6'd10, cc: 4'd12, seg: {7'h40, 7'h40, 7'h06, 7'h3F, 7'h40}};
    vecs[3] = '{mn: 6'd0,  sc: 6'd0,  cc: 4'd0,  seg: {7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[4] = '{mn: 6'd59, sc: 6'd59, cc: 4'd9,  seg: {7'h6D, 7'h6F, 7'h6D, 7'h6F, 7'h6F}};
    vecs[5] = '{mn: 6'd9,  sc: 6'd60, cc: 4'd9,  seg: {7'h00, 7'h6F, 7'h40, 7'h40, 7'h6F}};
    vecs[6] = '{mn: 6'd63, sc: 6'd63, cc: 4'd15, seg: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[7] = '{mn: 6'd10, sc: 6'd5,  cc: 4'd0,  seg: {7'h06, 7'h3F, 7'h3F, 7'h6D, 7'h3F}};

    min_v = 6'd0; sec_v = 6'd0; secc_v = 4'd0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    ka = -1; kb = -1;

    // Reset held: everything dark.
    repeat (3) tick();
    chk("rst.an",  ifa.digit_an, 5'b00000);
    chk("rst.seg", ifa.seg, 7'h00);
    chk("rst.dp",  ifa.dp, 1'b0);
    chk("rst.fs",  ifa.frame_start, 1'b0);
    chk("rst.b.an", ifb.digit_an, 5'b11111);

    // First edge after release: M10, frame_start, blank leading zero.
    reset_n = 1'b1;
    tick();
    chk("first.an",  ifa.digit_an, 5'b10000);
    chk("first.fs",  ifa.frame_start, 1'b1);
    chk("first.seg", ifa.seg, 7'h00);

    // Static table vectors, one full frame each.
    for (int i = 0; i < 8; i++) begin
      min_v = vecs[i].mn; sec_v = vecs[i].sc; secc_v = vecs[i].cc;
      run_frame(vecs[i], -1, 6'd0, 6'd0, 4'd0);
    end

    // Inputs change in the S10 slot: current frame keeps the old snapshot.
    min_v = 6'd12; sec_v = 6'd34; secc_v = 4'd5;
    run_frame(vecs[0], 8, 6'd56, 6'd7, 4'd8);
    run_frame(vecs[1], -1, 6'd0, 6'd0, 4'd0);

    // Timer wrap mid-frame.
    min_v = 6'd59; sec_v = 6'd59; secc_v = 4'd9;
    run_frame(vecs[4], 12, 6'd0, 6'd0, 4'd0);
    run_frame(vecs[3], -1, 6'd0, 6'd0, 4'd0);

    // Short asynchronous reset in the middle of slot S1.
    n = 0;
    while (!(ka >= 0 && (ka / 4) % 5 == 3 && ka % 4 == 1) && n < 40) begin
      tick();
      n++;
    end
    chk("s1.an", ifa.digit_an, 5'b00010);
    #1 reset_n = 1'b0;
    ka = -1; kb = -1;
    #1;
    chk("arst.an",  ifa.digit_an, 5'b00000);
    chk("arst.seg", ifa.seg, 7'h00);
    chk("arst.dp",  ifa.dp, 1'b0);
    chk("arst.b.seg", ifb.seg, 7'h7F);
    check_all("arst");
    #2 reset_n = 1'b1;
    tick();
    chk("rel.an", ifa.digit_an, 5'b10000);
    chk("rel.fs", ifa.frame_start, 1'b1);
    // Active-low, one clock per slot, 00:00.0.
    chk("b.m10.an",  ifb.digit_an, 5'b01111);
    chk("b.m10.seg", ifb.seg, 7'h7F);
    chk("b.m10.fs",  ifb.frame_start, 1'b1);
    tick();
    chk("b.m1.an",  ifb.digit_an, 5'b10111);
    chk("b.m1.seg", ifb.seg, 7'h40);
    chk("b.m1.dp",  ifb.dp, 1'b0);
    chk("b.m1.fs",  ifb.frame_start, 1'b0);

    // Randomized inputs and occasional reset pulses against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        min_v  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
        sec_v  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
        secc_v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 149) == 0) begin
        reset_n = 1'b0;
        ka = -1; kb = -1;
      end else begin
        reset_n = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
